// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and mux encodings for the multiply/divide sequencer
package muldiv_pkg;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        EXC   = 3'd4
    } state_e;

    localparam logic HILO_SEL_MULT = 1'b0;
    localparam logic HILO_SEL_DIV  = 1'b1;

    // HI/LO mux select that routes the result of the given unit
    function automatic logic hiloSelFor(input op_e op);
        return (op == OP_DIV) ? HILO_SEL_DIV : HILO_SEL_MULT;
    endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// rtl/muldiv_watchdog.sv - WAIT-state cycle counter with expiry compare
module muldiv_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expire
);
    import muldiv_pkg::*;

    logic [CNT_W-1:0] count;

    // Count WAIT cycles; restarted while the selected unit is being started
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // Fires during the last permitted WAIT cycle so the abort follows it directly
    assign expire = inc && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - MULT/DIV request sequencer driving unit starts and HI/LO writes; optional watchdog under MULDIV_TIMEOUT_EN
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic req_valid,
    input  logic req_op,
    output logic req_ready,
    output logic mult_start,
    input  logic mult_done,
    output logic div_start,
    input  logic div_done,
    input  logic div_by_zero,
    output logic hi_sel,
    output logic lo_sel,
    output logic hi_write,
    output logic lo_write,
    output logic busy,
    output logic op_done,
    output logic div_zero_exc,
    output logic timeout_err
);

    if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_badCntW
        $error("muldiv_sequencer: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_e state;
    op_e    opLatch;
    logic   selDone;

    // Only the unit that was started may complete the operation
    assign selDone = (opLatch == OP_DIV) ? div_done : mult_done;

`ifdef MULDIV_TIMEOUT_EN
    logic wdExpire;

    muldiv_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clock (clock),
        .reset (reset),
        .clear (state == START),
        .inc   (state == WAIT),
        .expire(wdExpire)
    );
`else
    assign timeout_err = 1'b0;
`endif

    // Control FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            opLatch      <= OP_MULT;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            mult_start   <= 1'b0;
            div_start    <= 1'b0;
            hi_sel       <= HILO_SEL_MULT;
            lo_sel       <= HILO_SEL_MULT;
            hi_write     <= 1'b0;
            lo_write     <= 1'b0;
            op_done      <= 1'b0;
            div_zero_exc <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
        end else begin
            mult_start   <= 1'b0;
            div_start    <= 1'b0;
            hi_write     <= 1'b0;
            lo_write     <= 1'b0;
            op_done      <= 1'b0;
            div_zero_exc <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state      <= START;
                        opLatch    <= op_e'(req_op);
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        mult_start <= (op_e'(req_op) == OP_MULT);
                        div_start  <= (op_e'(req_op) == OP_DIV);
                        hi_sel     <= hiloSelFor(op_e'(req_op));
                        lo_sel     <= hiloSelFor(op_e'(req_op));
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (opLatch == OP_DIV && div_by_zero) begin
                        state        <= EXC;
                        div_zero_exc <= 1'b1;
                    end else if (selDone) begin
                        state    <= WRITE;
                        hi_write <= 1'b1;
                        lo_write <= 1'b1;
                        op_done  <= 1'b1;
`ifdef MULDIV_TIMEOUT_EN
                    end else if (wdExpire) begin
                        state       <= EXC;
                        timeout_err <= 1'b1;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    hi_sel    <= HILO_SEL_MULT;
                    lo_sel    <= HILO_SEL_MULT;
                end
            endcase
        end
    end

endmodule
